iccm_preload_ctrl: RTL and testbench



---
 rtl/top_pkg.sv | 13 +
 rtl/preload_fifo.sv | 60 ++++++
 rtl/iccm_preload_ctrl.sv | 146 ++++++++++++++
 tb/tb_iccm_preload_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/top_pkg.sv
// Shared bus width and the ICCM write record carried through the program-load path.
package top_pkg;

   localparam int unsigned TL_DW   = 32;
   localparam int unsigned ICCM_AW = 11;

   typedef struct packed {
      logic [ICCM_AW-1:0] addr;
      logic [TL_DW-1:0]   data;
      logic [TL_DW-1:0]   mask;
   } iccm_wr_t;

endpackage

// File: rtl/preload_fifo.sv
// Two-entry synchronous FIFO; the head entry is visible combinationally.
module preload_fifo
   import top_pkg::*;
#(
   parameter type T = iccm_wr_t
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic push_i,
   input  logic pop_i,
   input  T     wdata_i,
   output T     head_o,
   output logic full_o,
   output logic empty_o
);

   T           mem0_q, mem1_q;
   logic       wptr_q, rptr_q;
   logic [1:0] cnt_q, cnt_d;
   logic       do_push_s, do_pop_s;

   assign full_o    = (cnt_q == 2'd2);
   assign empty_o   = (cnt_q == 2'd0);
   assign do_pop_s  = pop_i & ~empty_o;
   assign do_push_s = push_i & (~full_o | do_pop_s);
   assign head_o    = rptr_q ? mem1_q : mem0_q;

   always_comb begin
      cnt_d = cnt_q;
      case ({do_push_s, do_pop_s})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem0_q <= '0;
         mem1_q <= '0;
         wptr_q <= 1'b0;
         rptr_q <= 1'b0;
         cnt_q  <= 2'd0;
      end else begin
         if (do_push_s) begin
            if (wptr_q) begin
               mem1_q <= wdata_i;
            end else begin
               mem0_q <= wdata_i;
            end
            wptr_q <= ~wptr_q;
         end
         if (do_pop_s) begin
            rptr_q <= ~rptr_q;
         end
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/iccm_preload_ctrl.sv
// Program-load receiver: buffers host word writes, retires them to the ICCM,
// then sequences the core out of reset once the load has fully drained.
module iccm_preload_ctrl
   import top_pkg::*;
#(
   parameter int unsigned DW       = TL_DW,
   parameter int unsigned AW       = 11,
   parameter int unsigned RST_HOLD = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          tb2iccm_we,
   input  logic [DW-1:0] tb2mem_wdata,
   input  logic [DW-1:0] tb2mem_wmask,
   input  logic [AW-1:0] tb2mem_waddr,
   input  logic          tb2mem_finish,
   output logic          iccm_req_o,
   output logic          iccm_we_o,
   output logic [AW-1:0] iccm_addr_o,
   output logic [DW-1:0] iccm_wdata_o,
   output logic [DW-1:0] iccm_wmask_o,
   input  logic          iccm_gnt_i,
   output logic          core_rst_no,
   output logic          fetch_en_o,
   output logic          load_done_o,
   output logic [AW:0]   word_cnt_o,
   output logic          err_o
);

   localparam logic [1:0] ST_LOAD  = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [1:0] ST_RUN   = 2'd3;

   localparam int unsigned HCW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam int unsigned CW  = AW + 1;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [DW-1:0] mask;
   } wr_t;

   wr_t            push_data_s, head_s;
   logic           full_s, empty_s, req_s, pop_s, push_s;
   logic           host_wr_s, fin_rise_s, err_set_s, run_s;
   logic [1:0]     state_q, state_d;
   logic [HCW-1:0] hcnt_q, hcnt_d;
   logic [AW:0]    word_cnt_q, word_cnt_d;
   logic           fin_q, err_q, core_rst_q, fetch_en_q, load_done_q;

   assign host_wr_s   = ~tb2iccm_we;
   assign fin_rise_s  = tb2mem_finish & ~fin_q;
   assign req_s       = ~empty_s;
   assign pop_s       = req_s & iccm_gnt_i;
   // A full FIFO still takes a push when its head retires in the same cycle.
   assign push_s      = host_wr_s & (state_q == ST_LOAD) & (~full_s | pop_s);
   assign err_set_s   = host_wr_s & ((state_q != ST_LOAD) | (full_s & ~pop_s));
   assign run_s       = (state_q == ST_RUN);
   assign push_data_s = {tb2mem_waddr, tb2mem_wdata, tb2mem_wmask};

   preload_fifo #(.T(wr_t)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .wdata_i (push_data_s),
      .head_o  (head_s),
      .full_o  (full_s),
      .empty_o (empty_s)
   );

   assign iccm_req_o   = req_s;
   assign iccm_we_o    = req_s;
   assign iccm_addr_o  = head_s.addr;
   assign iccm_wdata_o = head_s.data;
   assign iccm_wmask_o = head_s.mask;

   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      case (state_q)
         ST_LOAD: begin
            if (fin_rise_s) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_DRAIN: begin
            if (empty_s) begin
               state_d = ST_HOLD;
               hcnt_d  = HCW'(RST_HOLD - 1);
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_HOLD: begin
            if (hcnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               hcnt_d = hcnt_q - HCW'(1);
            end
         end
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_LOAD;
      endcase
   end

   always_comb begin
      if (pop_s && (word_cnt_q != '1)) begin
         word_cnt_d = word_cnt_q + CW'(1);
      end else begin
         word_cnt_d = word_cnt_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_LOAD;
         hcnt_q      <= '0;
         word_cnt_q  <= '0;
         fin_q       <= 1'b0;
         err_q       <= 1'b0;
         core_rst_q  <= 1'b0;
         fetch_en_q  <= 1'b0;
         load_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hcnt_q      <= hcnt_d;
         word_cnt_q  <= word_cnt_d;
         fin_q       <= tb2mem_finish;
         err_q       <= err_q | err_set_s;
         core_rst_q  <= run_s;
         fetch_en_q  <= run_s;
         load_done_q <= load_done_q | run_s;
      end
   end

   assign core_rst_no = core_rst_q;
   assign fetch_en_o  = fetch_en_q;
   assign load_done_o = load_done_q;
   assign word_cnt_o  = word_cnt_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_iccm_preload_ctrl.sv
// Self-checking bench for iccm_preload_ctrl: queue-based reference of the load
// port plus directed scenarios with hand-computed expectations.
module tb_iccm_preload_ctrl;

   localparam int DW   = 32;
   localparam int AW   = 11;
   localparam int HOLD = 4;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [DW-1:0] m;
   } ent_t;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          we_n = 1'b1, finish = 1'b0, gnt = 1'b0;
   logic [AW-1:0] waddr = '0;
   logic [DW-1:0] wdata = '0, wmask = '0;
   logic          req, sram_we, core_rst_n, fetch_en, load_done, err;
   logic [AW-1:0] addr;
   logic [DW-1:0] sram_wdata, sram_wmask;
   logic [AW:0]   word_cnt;

   int   checks = 0, errors = 0;
   ent_t m_q[$];
   ent_t dut_log[$];
   int   m_cnt, m_mode, m_left, m_sz, lat;
   bit   m_err, m_run, m_fprev, m_pop, m_push;

   logic [DW-1:0] prog [4] = '{32'h40080437, 32'h00a00613, 32'h01400693, 32'h00d60733};

   always #5 clk = ~clk;

   iccm_preload_ctrl #(.DW(DW), .AW(AW), .RST_HOLD(HOLD)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .tb2iccm_we    (we_n),
      .tb2mem_wdata  (wdata),
      .tb2mem_wmask  (wmask),
      .tb2mem_waddr  (waddr),
      .tb2mem_finish (finish),
      .iccm_req_o    (req),
      .iccm_we_o     (sram_we),
      .iccm_addr_o   (addr),
      .iccm_wdata_o  (sram_wdata),
      .iccm_wmask_o  (sram_wmask),
      .iccm_gnt_i    (gnt),
      .core_rst_no   (core_rst_n),
      .fetch_en_o    (fetch_en),
      .load_done_o   (load_done),
      .word_cnt_o    (word_cnt),
      .err_o         (err)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: mode 0 load, 1 drain, 2 hold, 3 run; queue of at most two words.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_q.delete();
            dut_log.delete();
            m_cnt = 0; m_mode = 0; m_left = 0;
            m_err = 1'b0; m_run = 1'b0; m_fprev = 1'b0;
         end else begin
            if (req && gnt) dut_log.push_back({addr, sram_wdata, sram_wmask});
            m_sz   = m_q.size();
            m_pop  = (m_sz > 0) && gnt;
            m_push = 1'b0;
            if (!we_n) begin
               if (m_mode == 0 && (m_sz < 2 || m_pop)) m_push = 1'b1;
               else m_err = 1'b1;
            end
            if (m_pop) begin
               void'(m_q.pop_front());
               if (m_cnt < (1 << (AW + 1)) - 1) m_cnt++;
            end
            if (m_push) m_q.push_back({waddr, wdata, wmask});
            if (m_mode == 0 && finish && !m_fprev) m_mode = 1;
            else if (m_mode == 1 && m_sz == 0) begin
               m_mode = 2;
               m_left = HOLD + 1;
            end else if (m_mode == 2) begin
               m_left--;
               if (m_left == 0) begin
                  m_mode = 3;
                  m_run  = 1'b1;
               end
            end
            m_fprev = finish;
         end
      end
   end

   // Per-cycle comparison against the reference model.
   always @(negedge clk) begin
      if (rst_n) begin
         check("req", req, m_q.size() != 0);
         check("we", sram_we, m_q.size() != 0);
         if (m_q.size() != 0) begin
            check("addr", addr, m_q[0].a);
            check("wdata", sram_wdata, m_q[0].d);
            check("wmask", sram_wmask, m_q[0].m);
         end
         check("word_cnt", word_cnt, m_cnt);
         check("err", err, m_err);
         check("core_rst_n", core_rst_n, m_run);
         check("fetch_en", fetch_en, m_run);
         check("load_done", load_done, m_run);
      end
   end

   task automatic cyc(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] m, input bit fin, input bit g);
      @(negedge clk);
      we_n = ~wr; waddr = a; wdata = d; wmask = m; finish = fin; gnt = g;
   endtask

   task automatic idle(input bit fin, input bit g, input int n);
      repeat (n) cyc(1'b0, '0, '0, '0, fin, g);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #3 rst_n = 1'b0;
      we_n = 1'b1; finish = 1'b0; gnt = 1'b0;
      repeat (2) @(negedge clk);
      #3 rst_n = 1'b1;
   endtask

   task automatic wait_rel(output int l);
      l = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         @(negedge clk);
         we_n = 1'b1;
         if (core_rst_n) begin
            l = i - 1;
            break;
         end
      end
   endtask

   initial begin
      #1;
      check("rst_req", req, 1'b0);
      do_reset();
      @(negedge clk);
      check("rst_core_rst_n", core_rst_n, 1'b0);
      check("rst_word_cnt", word_cnt, 0);

      // Four back-to-back writes with grant held high, then finish.
      for (int i = 0; i < 4; i++) cyc(1'b1, AW'(i), prog[i], 32'hFFFFFFFF, 1'b0, 1'b1);
      cyc(1'b0, '0, '0, '0, 1'b1, 1'b1);
      wait_rel(lat);
      check("t1_release_latency", lat, 6);
      check("t1_nwrites", dut_log.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < dut_log.size()) begin
            check("t1_addr", dut_log[i].a, i);
            check("t1_data", dut_log[i].d, prog[i]);
         end
      end
      check("t1_word_cnt", word_cnt, 4);
      check("t1_err", err, 1'b0);
      check("t1_fetch_en", fetch_en, 1'b1);

      // Host write while running is rejected.
      cyc(1'b1, 11'h7FF, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b1, 1'b1);
      idle(1'b1, 1'b1, 3);
      check("t4_err", err, 1'b1);
      check("t4_word_cnt", word_cnt, 4);
      check("t4_nwrites", dut_log.size(), 4);

      // Grant low for three cycles: third write overflows.
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1'b1, AW'(i), prog[i], 32'hFFFFFFFF, 1'b0, i == 3);
      idle(1'b0, 1'b1, 4);
      check("t2_nwrites", dut_log.size(), 3);
      if (dut_log.size() == 3) begin
         check("t2_addr0", dut_log[0].a, 0);
         check("t2_addr1", dut_log[1].a, 1);
         check("t2_addr2", dut_log[2].a, 3);
         check("t2_data2", dut_log[2].d, 32'h00d60733);
      end
      check("t2_err", err, 1'b1);
      check("t2_word_cnt", word_cnt, 3);

      // Eight writes at one-in-two rate, grant toggling each cycle.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, AW'(i + 16), 32'h01010101 * i, (i % 2 == 1) ? 32'h0 : 32'hFFFFFFFF, 1'b0, 1'b1);
         cyc(1'b0, '0, '0, '0, 1'b0, 1'b0);
      end
      idle(1'b0, 1'b1, 3);
      check("t3_nwrites", dut_log.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < dut_log.size()) begin
            check("t3_addr", dut_log[i].a, i + 16);
            check("t3_mask", dut_log[i].m, (i % 2 == 1) ? 32'h0 : 32'hFFFFFFFF);
         end
      end
      check("t3_word_cnt", word_cnt, 8);
      check("t3_err", err, 1'b0);

      // Reset while two entries wait in drain.
      do_reset();
      cyc(1'b1, 11'h10, 32'h11111111, 32'hFFFFFFFF, 1'b0, 1'b0);
      cyc(1'b1, 11'h11, 32'h22222222, 32'hFFFFFFFF, 1'b0, 1'b0);
      cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);
      idle(1'b1, 1'b0, 2);
      check("t5_req_before", req, 1'b1);
      check("t5_addr_before", addr, 11'h10);
      #3 rst_n = 1'b0;
      #1;
      check("t5_req", req, 1'b0);
      check("t5_core_rst_n", core_rst_n, 1'b0);
      check("t5_word_cnt", word_cnt, 0);
      finish = 1'b0;
      @(negedge clk);
      #3 rst_n = 1'b1;
      cyc(1'b1, 11'h9, 32'h99999999, 32'hFFFFFFFF, 1'b0, 1'b1);
      @(negedge clk);
      we_n = 1'b1;
      check("t5_load_req", req, 1'b1);
      check("t5_load_addr", addr, 11'h9);
      idle(1'b0, 1'b1, 2);
      check("t5_load_cnt", word_cnt, 1);

      // Finish edge coincides with the write to address 5.
      do_reset();
      cyc(1'b1, 11'h4, 32'h44444444, 32'hFFFFFFFF, 1'b0, 1'b1);
      cyc(1'b1, 11'h5, 32'h55555555, 32'hFFFFFFFF, 1'b1, 1'b1);
      wait_rel(lat);
      check("t6_release_latency", lat, 7);
      check("t6_nwrites", dut_log.size(), 2);
      if (dut_log.size() == 2) check("t6_last_addr", dut_log[1].a, 11'h5);
      check("t6_word_cnt", word_cnt, 2);
      check("t6_err", err, 1'b0);

      idle(1'b0, 1'b1, 2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
